// File: rtl/rf_cmd_parser_pkg.sv
// Shared constants, FSM state type and frame validation rule for the RF command parser.
package rf_cmd_parser_pkg;

  localparam logic [7:0] OP_ON      = 8'hFF;
  localparam logic [7:0] OP_OFF     = 8'h00;
  localparam logic [7:0] OP_ALL_OFF = 8'hF0;

  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ARG = 2'd1,
    ST_EXEC     = 2'd2
  } state_e;

  // Payload is {ch[7:4], code[3:0]}; ALL_OFF ignores ch but demands an all-zero payload.
  function automatic logic frame_ok(input logic [7:0]  op,
                                    input logic [7:0]  pl,
                                    input int unsigned num_ch,
                                    input int unsigned num_codes);
    logic ch_ok;
    logic code_ok;
    logic ok;
    ch_ok   = {28'd0, pl[7:4]} < num_ch;
    code_ok = {28'd0, pl[3:0]} < num_codes;
    case (op)
      OP_ON:      ok = ch_ok & code_ok;
      OP_OFF:     ok = ch_ok;
      OP_ALL_OFF: ok = (pl == 8'h00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rf_cmd_parser_if.sv
// Byte-stream bus between the UART side (master) and the command parser (slave).
interface rf_cmd_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output rx_data, rx_valid, tx_ready, input tx_data, tx_valid);
  modport slave  (input rx_data, rx_valid, tx_ready, output tx_data, tx_valid);
endinterface

// File: rtl/rf_cmd_parser_resp_buf.sv
// Single-entry valid/ready response holding register with a sticky overflow flag.
module rf_cmd_resp_buf (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       ack_ovf
);

  logic accept;

  // A handshake in the same cycle frees the slot, so the new byte can take it.
  assign accept = load & (~tx_valid | tx_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
      ack_ovf  <= 1'b0;
    end else begin
      if (accept) begin
        tx_data  <= load_data;
        tx_valid <= 1'b1;
      end else begin
        if (load) begin
          ack_ovf <= 1'b1;
        end
        if (tx_valid && tx_ready) begin
          tx_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/rf_cmd_parser.sv
// Two-byte frame parser driving per-channel RF enable/code registers with ACK/NAK replies.
module rf_cmd_parser
  import rf_cmd_parser_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned NUM_CODES   = 8,
  parameter int unsigned CODE_W      = 3,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                       M_CLK_OSC,
  input  logic                       M_RESET_B,
  rf_cmd_parser_if.slave             bus,
  output logic [NUM_CH-1:0]          ch_en,
  output logic [NUM_CH*CODE_W-1:0]   ch_code,
  output logic                       cmd_strobe,
  output logic                       any_active,
  output logic                       frame_err,
  output logic                       ack_ovf
);

  localparam int unsigned     TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_e                     state_q, state_d;
  logic [7:0]                 opcode_q, opcode_d;
  logic [7:0]                 payload_q, payload_d;
  logic [TMR_W-1:0]           timer_q, timer_d;
  logic [NUM_CH-1:0]          ch_en_d;
  logic [NUM_CH*CODE_W-1:0]   ch_code_d;
  logic                       strobe_d;
  logic                       frame_err_d;
  logic                       rsp_load;
  logic [7:0]                 rsp_data;
  logic                       ok;

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    payload_d   = payload_q;
    timer_d     = timer_q;
    ch_en_d     = ch_en;
    ch_code_d   = ch_code;
    strobe_d    = 1'b0;
    frame_err_d = 1'b0;
    rsp_load    = 1'b0;
    rsp_data    = RSP_NAK;
    ok          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          opcode_d = bus.rx_data;
          timer_d  = '0;
          state_d  = ST_WAIT_ARG;
        end
      end

      ST_WAIT_ARG: begin
        // A byte in the final counting cycle wins over the timeout.
        if (bus.rx_valid) begin
          payload_d = bus.rx_data;
          state_d   = ST_EXEC;
        end else if (timer_q == TMR_LAST) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_EXEC: begin
        ok          = frame_ok(opcode_q, payload_q, NUM_CH, NUM_CODES);
        rsp_load    = 1'b1;
        rsp_data    = ok ? RSP_ACK : RSP_NAK;
        frame_err_d = bus.rx_valid;
        state_d     = ST_IDLE;
        if (ok) begin
          strobe_d = 1'b1;
          case (opcode_q)
            OP_ON: begin
              for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (payload_q[7:4] == 4'(i)) begin
                  ch_en_d[i]                  = 1'b1;
                  ch_code_d[i*CODE_W +: CODE_W] = CODE_W'(payload_q[3:0]);
                end
              end
            end
            OP_OFF: begin
              for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (payload_q[7:4] == 4'(i)) begin
                  ch_en_d[i] = 1'b0;
                end
              end
            end
            OP_ALL_OFF: ch_en_d = '0;
            default: ;
          endcase
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge M_CLK_OSC or negedge M_RESET_B) begin
    if (!M_RESET_B) begin
      state_q    <= ST_IDLE;
      opcode_q   <= '0;
      payload_q  <= '0;
      timer_q    <= '0;
      ch_en      <= '0;
      ch_code    <= '0;
      cmd_strobe <= 1'b0;
      frame_err  <= 1'b0;
      any_active <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      payload_q  <= payload_d;
      timer_q    <= timer_d;
      ch_en      <= ch_en_d;
      ch_code    <= ch_code_d;
      cmd_strobe <= strobe_d;
      frame_err  <= frame_err_d;
      // Computed from the next enables so the LED flag lines up with ch_en.
      any_active <= |ch_en_d;
    end
  end

  rf_cmd_resp_buf u_resp_buf (
    .clk       (M_CLK_OSC),
    .rst_n     (M_RESET_B),
    .load      (rsp_load),
    .load_data (rsp_data),
    .tx_ready  (bus.tx_ready),
    .tx_data   (bus.tx_data),
    .tx_valid  (bus.tx_valid),
    .ack_ovf   (ack_ovf)
  );

endmodule
